mag_power_scheduler: RTL and testbench

- Synchronous cook sequencer for the microwave magnetron.
- Converts front-panel buttons (startn, stopn, clearn), door_closed and timer_done into a cook state.
- Produces a power-level duty-cycled mag_on. Duty cycle: magnetron on for power_level ticks out of every WINDOW ticks.
- Sits between the panel/timer logic and the magnetron drive. It is the clocked successor of the set/reset latch controller.

---
 rtl/mag_power_scheduler.sv | 157 +++++++++++++++
 tb/tb_mag_power_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mag_power_scheduler.sv
// Magnetron cook sequencer: turns panel buttons, door and timer status into a cook
// state and a duty-cycled magnetron enable (power_level ticks on out of WINDOW).
// Optional done beep is compiled in with `define MAG_DONE_BEEP_EN.
module mag_power_scheduler #(
    parameter int WINDOW     = 10,
    parameter int CW         = 4,
    parameter int BEEP_TICKS = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          startn,
    input  logic          stopn,
    input  logic          clearn,
    input  logic          door_closed,
    input  logic          timer_done,
    input  logic          tick,
    input  logic [CW-1:0] power_level,
    output logic [1:0]    state,
    output logic          mag_on,
    output logic          beep
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StCook  = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_t;

    localparam logic [CW-1:0] WinMax  = CW'(WINDOW);
    localparam logic [CW-1:0] WinLast = CW'(WINDOW - 1);

    // Reject configurations the counter or beep logic cannot represent.
    if ((1 << CW) <= WINDOW) begin : g_bad_cw
        $error("CW too narrow for WINDOW");
    end
    if (BEEP_TICKS < 1) begin : g_bad_beep
        $error("BEEP_TICKS must be at least 1");
    end

    state_t        state_q, state_d;
    logic [CW-1:0] win_q, win_d;
    logic [CW-1:0] level_q, level_d;
    logic          start_q, stop_q, clear_q;
    logic          start_raw, stop_raw, clear_raw;
    logic          start_ev, stop_ev, clear_ev;
    logic [CW-1:0] level_cap;

    // Falling-edge detect; only the highest-priority event acts (clear > stop > start).
    assign start_raw = start_q & ~startn;
    assign stop_raw  = stop_q & ~stopn;
    assign clear_raw = clear_q & ~clearn;
    assign clear_ev  = clear_raw;
    assign stop_ev   = stop_raw & ~clear_raw;
    assign start_ev  = start_raw & ~stop_raw & ~clear_raw;

    assign level_cap = (power_level > WinMax) ? WinMax : power_level;

    // Button history, state, window counter and captured power level.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b1;
            stop_q  <= 1'b1;
            clear_q <= 1'b1;
            state_q <= StIdle;
            win_q   <= '0;
            level_q <= '0;
        end else begin
            start_q <= startn;
            stop_q  <= stopn;
            clear_q <= clearn;
            state_q <= state_d;
            win_q   <= win_d;
            level_q <= level_d;
        end
    end

    // Next-state, window advance and level capture.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        level_d = level_q;
        unique case (state_q)
            StIdle: begin
                if (start_ev && door_closed && !timer_done && (power_level != '0)) begin
                    state_d = StCook;
                    level_d = level_cap;
                end
            end
            StCook: begin
                if (tick) begin
                    win_d = (win_q == WinLast) ? '0 : win_q + 1'b1;
                end
                if (clear_ev) begin
                    state_d = StIdle;
                end else if (stop_ev || !door_closed) begin
                    state_d = StPause;
                end else if (timer_done) begin
                    state_d = StDone;
                end
            end
            StPause: begin
                // Resume keeps the frozen window position.
                if (clear_ev || stop_ev) begin
                    state_d = StIdle;
                end else if (start_ev && door_closed && !timer_done) begin
                    state_d = StCook;
                    level_d = level_cap;
                end
            end
            StDone: begin
                if (clear_ev || stop_ev || !door_closed) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StIdle) begin
            win_d = '0;
        end
    end

    // Door term is combinational so an opening door cuts power before the state updates.
    assign mag_on = (state_q == StCook) && (win_q < level_q) && door_closed;
    assign state  = state_q;

`ifdef MAG_DONE_BEEP_EN
    localparam int BW = $clog2(BEEP_TICKS + 1);

    logic          beep_q;
    logic [BW-1:0] beep_cnt_q;

    // Beep for BEEP_TICKS ticks after entering DONE; cleared on leaving DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
        end else if (state_d == StDone && state_q != StDone) begin
            beep_q     <= 1'b1;
            beep_cnt_q <= BW'(BEEP_TICKS);
        end else if (state_d != StDone) begin
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
        end else if (tick && beep_cnt_q != '0) begin
            beep_cnt_q <= beep_cnt_q - 1'b1;
            if (beep_cnt_q == BW'(1)) begin
                beep_q <= 1'b0;
            end
        end
    end

    assign beep = beep_q;
`else
    assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_mag_power_scheduler.sv
// Directed bench for mag_power_scheduler with hand-computed expectations.
module tb_mag_power_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       startn, stopn, clearn, door_closed, timer_done, tick;
    logic [3:0] power_level;
    logic [1:0] state;
    logic       mag_on, beep;

    int n_total = 0;
    int n_pass  = 0;

    mag_power_scheduler #(.WINDOW(10), .CW(4), .BEEP_TICKS(3)) dut (
        .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .timer_done(timer_done), .tick(tick),
        .power_level(power_level), .state(state), .mag_on(mag_on), .beep(beep)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle press: the event acts at the first edge.
    task automatic press_start();
        startn = 1'b0; cyc(1); startn = 1'b1; cyc(1);
    endtask
    task automatic press_stop();
        stopn = 1'b0; cyc(1); stopn = 1'b1; cyc(1);
    endtask
    task automatic press_clear();
        clearn = 1'b0; cyc(1); clearn = 1'b1; cyc(1);
    endtask
    task automatic do_tick();
        tick = 1'b1; cyc(1); tick = 1'b0;
    endtask

    int w;
    int entries;
    logic [1:0] prev_state;

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        startn = 1'($urandom); stopn = 1'($urandom); clearn = 1'($urandom);
        door_closed = 1'($urandom); timer_done = 1'($urandom); tick = 1'($urandom);
        power_level = 4'($urandom);
        cyc(2);
        check("rst_state", state, 0);
        check("rst_mag", mag_on, 0);
        check("rst_beep", beep, 0);
        startn = 1; stopn = 1; clearn = 1; door_closed = 1; timer_done = 0; tick = 0;
        power_level = 3;
        rst = 1'b0;
        cyc(1);
        check("idle_after_rst", state, 0);

        // Level 3 duty pattern over two windows
        press_start();
        check("start_cook", state, 1);
        w = 0;
        for (int k = 0; k < 20; k++) begin
            check($sformatf("duty3_w%0d", w), mag_on, (w < 3) ? 1 : 0);
            do_tick();
            w = (w + 1) % 10;
        end
        press_clear();
        check("clear_idle", state, 0);

        // Door opens mid-window at level 10, then resume at level 5
        power_level = 10;
        press_start();
        for (int k = 0; k < 4; k++) do_tick();
        check("lvl10_on", mag_on, 1);
        door_closed = 1'b0;
        #1;
        check("door_mag_comb", mag_on, 0);
        check("door_state_same", state, 1);
        cyc(1);
        check("door_pause", state, 2);
        door_closed = 1'b1;
        cyc(3);
        check("pause_hold", state, 2);
        check("pause_mag", mag_on, 0);
        do_tick();
        check("pause_tick_hold", state, 2);
        power_level = 5;
        press_start();
        check("resume_cook", state, 1);
        check("resume_w4_on", mag_on, 1);
        do_tick();
        check("resume_w5_off", mag_on, 0);

        // Simultaneous buttons in COOK, then start+stop in IDLE
        startn = 0; stopn = 0; clearn = 0;
        cyc(1);
        check("all_btn_idle", state, 0);
        startn = 1; stopn = 1; clearn = 1;
        cyc(1);
        startn = 0; stopn = 0;
        cyc(1);
        check("start_stop_idle", state, 0);
        startn = 1; stopn = 1;
        cyc(1);

        // Refused starts and clamped level
        power_level = 0;
        press_start();
        check("pwr0_refused", state, 0);
        power_level = 3; door_closed = 0;
        press_start();
        check("door_open_refused", state, 0);
        door_closed = 1; timer_done = 1;
        press_start();
        check("timer_refused", state, 0);
        timer_done = 0; power_level = 15;
        press_start();
        check("pwr15_cook", state, 1);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("pwr15_on_%0d", k), mag_on, 1);
            do_tick();
        end

        // Timer expiry and done beep
        timer_done = 1'b1;
        cyc(1);
        check("done_state", state, 3);
        check("done_mag", mag_on, 0);
        for (int k = 0; k < 5; k++) begin
`ifdef MAG_DONE_BEEP_EN
            check($sformatf("beep_%0d", k), beep, (k < 3) ? 1 : 0);
`else
            check($sformatf("beep_%0d", k), beep, 0);
`endif
            do_tick();
        end
        press_start();
        check("done_start_ignored", state, 3);
        timer_done = 1'b0;
        press_clear();
        check("done_clear", state, 0);
        check("done_clear_beep", beep, 0);

        // Held start gives one event; stop twice goes PAUSE then IDLE
        power_level = 3;
        entries = 0;
        prev_state = state;
        startn = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cyc(1);
            if (prev_state == 2'd0 && state == 2'd1) entries++;
            prev_state = state;
        end
        startn = 1'b1;
        cyc(1);
        check("held_one_entry", entries, 1);
        check("held_cook", state, 1);
        press_stop();
        check("stop1_pause", state, 2);
        press_stop();
        check("stop2_idle", state, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
